// File: rtl/vram_arbiter_m_pkg.sv
// VRAM address-map constants and shared arbiter types.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vram_arbiter_m_pkg;

    localparam logic [15:0] VRAM_BASE = 16'h3700;
    localparam logic [15:0] VRAM_SIZE = 16'h0900;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CPU_RD  = 2'd1,
        ST_CPU_OOR = 2'd2
    } rd_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    function automatic logic offset_in_range(input logic [ADDR_W-1:0] off, input int depth);
        return (int'(off) < depth);
    endfunction

endpackage

// File: rtl/vram_arbiter_m_wfifo.sv
// Posted-write FIFO for the VRAM arbiter, head entry visible combinationally.
// Latency: pushed entry becomes the head one cycle after the push.
// Backpressure: push ignored while full, pop ignored while empty.
module vram_wfifo_m #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign head_dat = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/vram_arbiter_m.sv
// Single-port VRAM arbiter: posted CPU writes, stalled CPU reads, video fetch.
// Latency: write ack 0 cycles, read ack 1 cycle after grant, video data 1 cycle after grant.
// Backpressure: CPU held (no ack) on full FIFO or lost arbitration; denied video must hold vid_req.
module vram_arbiter_m
    import vram_arbiter_m_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int VRAM_DEPTH   = 2304
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_vblank,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [11:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    input  logic        vid_req,
    input  logic [11:0] vid_addr,
    output logic        vid_gnt,
    output logic        vid_rvalid,
    output logic [7:0]  vid_rdata,
    output logic [11:0] vram_addr,
    output logic        vram_we,
    output logic [7:0]  vram_wdata,
    input  logic [7:0]  vram_rdata
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    rd_state_t     state;
    logic [SW-1:0] starve_cnt;
    wr_entry_t     head;
    wr_entry_t     push_ent;
    logic          fifo_full;
    logic          fifo_empty;

    logic addr_ok;
    logic wr_acc;
    logic wr_push;
    logic rd_pend;
    logic oor_rd;
    logic cpu_cand;
    logic cpu_wins;
    logic drain;
    logic rd_gnt;

    assign push_ent = '{addr: cpu_addr, data: cpu_wdata};

    vram_wfifo_m #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(wr_entry_t))
    ) u_wfifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (wr_push),
        .push_dat (push_ent),
        .pop      (drain),
        .head_dat (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Out-of-range writes are acknowledged even when full: they never occupy an entry.
    assign addr_ok = offset_in_range(cpu_addr, VRAM_DEPTH);
    assign wr_acc  = cpu_req & cpu_we & (~addr_ok | ~fifo_full);
    assign wr_push = cpu_req & cpu_we & addr_ok & ~fifo_full;

    // Reads wait for an empty FIFO so they always observe earlier posted writes.
    assign rd_pend = cpu_req & ~cpu_we & addr_ok & fifo_empty & (state == ST_IDLE);
    assign oor_rd  = cpu_req & ~cpu_we & ~addr_ok & (state == ST_IDLE);

    assign cpu_cand = ~fifo_empty | rd_pend;
    assign cpu_wins = cpu_cand & (in_vblank | ~vid_req | (starve_cnt == STARVE_MAX));
    assign drain    = cpu_wins & ~fifo_empty;
    assign rd_gnt   = cpu_wins & fifo_empty;
    assign vid_gnt  = vid_req & ~cpu_wins;

    always_comb begin
        vram_addr  = '0;
        vram_we    = 1'b0;
        vram_wdata = '0;
        if (drain) begin
            vram_addr  = head.addr;
            vram_we    = 1'b1;
            vram_wdata = head.data;
        end else if (rd_gnt) begin
            vram_addr = cpu_addr;
        end else if (vid_gnt) begin
            vram_addr = vid_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            starve_cnt <= '0;
            vid_rvalid <= 1'b0;
        end else begin
            vid_rvalid <= vid_gnt;

            if (cpu_wins) begin
                starve_cnt <= '0;
            end else if (cpu_cand && (starve_cnt != STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (rd_gnt) begin
                        state <= ST_CPU_RD;
                    end else if (oor_rd) begin
                        state <= ST_CPU_OOR;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cpu_ack   = wr_acc | (state != ST_IDLE);
    assign cpu_rdata = (state == ST_CPU_RD) ? vram_rdata : 8'h00;
    assign vid_rdata = vid_rvalid ? vram_rdata : 8'h00;

endmodule

// File: tb/tb_vram_arbiter_m.sv
// Directed bench for vram_arbiter_m with a behavioural synchronous VRAM.
// Inputs driven on the falling edge, outputs sampled 2 time units later.
module tb_vram_arbiter_m;

    logic        clk;
    logic        rst_n;
    logic        in_vblank;
    logic        cpu_req;
    logic        cpu_we;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        vid_req;
    logic [11:0] vid_addr;
    logic        vid_gnt;
    logic        vid_rvalid;
    logic [7:0]  vid_rdata;
    logic [11:0] vram_addr;
    logic        vram_we;
    logic [7:0]  vram_wdata;
    logic [7:0]  vram_rdata = 8'h00;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:2303];
    logic       preloaded = 1'b0;
    int         vram_wr_cnt = 0;
    logic [39:0] obs;

    vram_arbiter_m #(
        .FIFO_DEPTH   (4),
        .STARVE_LIMIT (8),
        .VRAM_DEPTH   (2304)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_vblank  (in_vblank),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_gnt    (vid_gnt),
        .vid_rvalid (vid_rvalid),
        .vid_rdata  (vid_rdata),
        .vram_addr  (vram_addr),
        .vram_we    (vram_we),
        .vram_wdata (vram_wdata),
        .vram_rdata (vram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    function automatic logic [7:0] pat(input logic [11:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 2304; i++) mem[i] <= pat(12'(i));
            preloaded <= 1'b1;
        end else if (vram_we && (vram_addr < 12'd2304)) begin
            mem[vram_addr] <= vram_wdata;
        end
        if (vram_we) vram_wr_cnt <= vram_wr_cnt + 1;
        vram_rdata <= (vram_addr < 12'd2304) ? mem[vram_addr] : 8'h00;
    end

    assign obs = {cpu_ack, cpu_rdata, vid_gnt, vid_rvalid, vid_rdata, vram_we, vram_addr, vram_wdata};

    typedef struct packed {
        logic        vb;
        logic        creq;
        logic        cwe;
        logic [11:0] caddr;
        logic [7:0]  cwd;
        logic        vreq;
        logic [11:0] vaddr;
        logic [39:0] exp;
    } vec_t;

    function automatic vec_t mkv(
        input logic vb, input logic creq, input logic cwe, input logic [11:0] caddr,
        input logic [7:0] cwd, input logic vreq, input logic [11:0] vaddr,
        input logic ack, input logic [7:0] crd, input logic gnt, input logic rv,
        input logic [7:0] vrd, input logic we, input logic [11:0] addr, input logic [7:0] wd);
        vec_t v;
        v.vb    = vb;
        v.creq  = creq;
        v.cwe   = cwe;
        v.caddr = caddr;
        v.cwd   = cwd;
        v.vreq  = vreq;
        v.vaddr = vaddr;
        v.exp   = {ack, crd, gnt, rv, vrd, we, addr, wd};
        return v;
    endfunction

    task automatic drive(input logic vb, input logic creq, input logic cwe, input logic [11:0] ca,
                         input logic [7:0] cd, input logic vr, input logic [11:0] va);
        in_vblank = vb;
        cpu_req   = creq;
        cpu_we    = cwe;
        cpu_addr  = ca;
        cpu_wdata = cd;
        vid_req   = vr;
        vid_addr  = va;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    vec_t vecs [14];
    int          wr_idx;
    int          drn;
    int          wr_before;
    logic        prev_gnt;
    logic        exp_ack;
    logic        exp_we;
    logic [11:0] prev_va;
    logic [11:0] va;
    logic [11:0] ea;
    logic [7:0]  ed;

    initial begin
        //             vb   creq cwe  caddr    cwd    vreq vaddr     ack  crd    gnt  rv   vrd    we   addr     wd
        vecs[0]  = mkv(1'b0,1'b0,1'b0,12'h000,8'h00,1'b0,12'h000, 1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,12'h000,8'h00);
        vecs[1]  = mkv(1'b0,1'b1,1'b1,12'h002,8'hA5,1'b0,12'h000, 1'b1,8'h00,1'b0,1'b0,8'h00,1'b0,12'h000,8'h00);
        vecs[2]  = mkv(1'b0,1'b0,1'b0,12'h000,8'h00,1'b0,12'h000, 1'b0,8'h00,1'b0,1'b0,8'h00,1'b1,12'h002,8'hA5);
        vecs[3]  = mkv(1'b0,1'b1,1'b0,12'h002,8'h00,1'b0,12'h000, 1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,12'h002,8'h00);
        vecs[4]  = mkv(1'b0,1'b1,1'b0,12'h002,8'h00,1'b0,12'h000, 1'b1,8'hA5,1'b0,1'b0,8'h00,1'b0,12'h000,8'h00);
        vecs[5]  = mkv(1'b0,1'b0,1'b0,12'h000,8'h00,1'b1,12'h010, 1'b0,8'h00,1'b1,1'b0,8'h00,1'b0,12'h010,8'h00);
        vecs[6]  = mkv(1'b0,1'b0,1'b0,12'h000,8'h00,1'b1,12'h011, 1'b0,8'h00,1'b1,1'b1,8'h4A,1'b0,12'h011,8'h00);
        vecs[7]  = mkv(1'b0,1'b0,1'b0,12'h000,8'h00,1'b0,12'h000, 1'b0,8'h00,1'b0,1'b1,8'h4B,1'b0,12'h000,8'h00);
        vecs[8]  = mkv(1'b0,1'b1,1'b1,12'h005,8'h77,1'b1,12'h020, 1'b1,8'h00,1'b1,1'b0,8'h00,1'b0,12'h020,8'h00);
        vecs[9]  = mkv(1'b0,1'b0,1'b0,12'h000,8'h00,1'b1,12'h021, 1'b0,8'h00,1'b1,1'b1,8'h7A,1'b0,12'h021,8'h00);
        vecs[10] = mkv(1'b0,1'b0,1'b0,12'h000,8'h00,1'b0,12'h000, 1'b0,8'h00,1'b0,1'b1,8'h7B,1'b1,12'h005,8'h77);
        vecs[11] = mkv(1'b0,1'b1,1'b0,12'h900,8'h00,1'b0,12'h000, 1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,12'h000,8'h00);
        vecs[12] = mkv(1'b0,1'b1,1'b0,12'h900,8'h00,1'b0,12'h000, 1'b1,8'h00,1'b0,1'b0,8'h00,1'b0,12'h000,8'h00);
        vecs[13] = mkv(1'b0,1'b0,1'b0,12'h000,8'h00,1'b0,12'h000, 1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,12'h000,8'h00);

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 12'h000);
        repeat (3) @(negedge clk);
        #2;
        chk("reset_outputs", 64'(obs), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle write/read, video latency, out-of-range read.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vecs[i].vb, vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].cwd, vecs[i].vreq, vecs[i].vaddr);
            #2;
            chk($sformatf("vec%0d", i), 64'(obs), 64'(vecs[i].exp));
        end

        // Five writes under continuous video: FIFO fill, starvation slots every 9 cycles.
        wr_idx   = 0;
        drn      = 0;
        prev_gnt = 1'b0;
        prev_va  = 12'h000;
        for (int cyc = 0; cyc <= 48; cyc++) begin
            @(negedge clk);
            va = 12'h040 + 12'(cyc);
            ea = 12'h100 + 12'(wr_idx);
            ed = 8'h11 + 8'(wr_idx);
            drive(1'b0, wr_idx < 5, 1'b1, ea, ed, 1'b1, va);
            #2;
            exp_ack = (cyc < 4) || (cyc == 10);
            exp_we  = (cyc >= 9) && (cyc <= 45) && (cyc % 9 == 0);
            chk("fill_ack", 64'(cpu_ack), 64'(exp_ack));
            chk("drain_slot", 64'(vram_we), 64'(exp_we));
            chk("vid_gnt_prio", 64'(vid_gnt), 64'(!exp_we));
            chk("vid_rdata", 64'({vid_rvalid, vid_rdata}),
                64'({prev_gnt, (prev_gnt ? pat(prev_va) : 8'h00)}));
            if (exp_we) begin
                ea = 12'h100 + 12'(drn);
                ed = 8'h11 + 8'(drn);
                chk("drain_entry", 64'({vram_addr, vram_wdata}), 64'({ea, ed}));
                drn++;
            end
            prev_gnt = !exp_we;
            prev_va  = va;
            if (cpu_ack) wr_idx++;
        end

        // Vblank: queued writes drain ahead of a requesting video engine.
        drn = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            ea = 12'h200 + 12'(cyc);
            ed = 8'h21 + 8'(cyc);
            drive(cyc >= 3, cyc < 3, 1'b1, ea, ed, 1'b1, 12'h050);
            #2;
            exp_we = (cyc >= 3) && (cyc <= 5);
            chk("vb_ack", 64'(cpu_ack), 64'(cyc < 3));
            chk("vb_drain", 64'(vram_we), 64'(exp_we));
            chk("vb_gnt", 64'(vid_gnt), 64'(!exp_we));
            if (exp_we) begin
                ea = 12'h200 + 12'(drn);
                ed = 8'h21 + 8'(drn);
                chk("vb_entry", 64'({vram_addr, vram_wdata}), 64'({ea, ed}));
                drn++;
            end
        end
        chk("vb_mem", 64'(mem[12'h202]), 64'h23);

        // Last valid byte: read-after-write ordering, then out-of-range write/read.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 12'h8FF, 8'h3C, 1'b0, 12'h000);
        #2;
        chk("bnd_wr_ack", 64'(cpu_ack), 64'h1);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 12'h8FF, 8'h00, 1'b0, 12'h000);
        #2;
        chk("bnd_raw_drain", 64'({cpu_ack, vram_we, vram_addr, vram_wdata}), 64'({1'b0, 1'b1, 12'h8FF, 8'h3C}));
        @(negedge clk);
        #2;
        chk("bnd_rd_gnt", 64'({cpu_ack, vram_we, vram_addr}), 64'({1'b0, 1'b0, 12'h8FF}));
        @(negedge clk);
        #2;
        chk("bnd_rd_data", 64'({cpu_ack, cpu_rdata}), 64'({1'b1, 8'h3C}));
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 12'h900, 8'hEE, 1'b0, 12'h000);
        #2;
        chk("oor_wr_ack", 64'(cpu_ack), 64'h1);
        repeat (3) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 12'h000);
            #2;
            chk("oor_wr_no_we", 64'(vram_we), 64'h0);
        end
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 12'h900, 8'h00, 1'b0, 12'h000);
        #2;
        chk("oor_rd_noport", 64'({cpu_ack, vram_we, vram_addr}), 64'h0);
        @(negedge clk);
        #2;
        chk("oor_rd_ack", 64'({cpu_ack, cpu_rdata}), 64'({1'b1, 8'h00}));

        // Reset with three posted writes still queued behind video.
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            ea = 12'h300 + 12'(cyc);
            ed = 8'h31 + 8'(cyc);
            drive(1'b0, 1'b1, 1'b1, ea, ed, 1'b1, 12'h060);
            #2;
            chk("rst_fill_ack", 64'(cpu_ack), 64'h1);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 12'h000);
        rst_n     = 1'b0;
        wr_before = vram_wr_cnt;
        #2;
        chk("rst_outputs_mid", 64'(obs), 64'h0);
        @(negedge clk);
        #2;
        chk("rst_hold", 64'(obs), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #2;
        chk("rst_no_writes", 64'(vram_wr_cnt), 64'(wr_before));
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 12'h310, 8'h99, 1'b0, 12'h000);
        #2;
        chk("post_rst_ack", 64'(cpu_ack), 64'h1);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 12'h000);
        #2;
        chk("post_rst_drain", 64'({vram_we, vram_addr, vram_wdata}), 64'({1'b1, 12'h310, 8'h99}));
        @(negedge clk);
        #2;
        chk("post_rst_empty", 64'(vram_we), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
